// File: rtl/aludec_pipe.sv
// Registered MIPS ALU-control decode stage with a DEPTH-entry valid/ready queue and flush.
// Optional reserved-instruction tagging is built when ALUDEC_RI_EN is defined.
module aludec_pipe #(
    parameter int DEPTH     = 2,
    parameter int ALUCTRL_W = 8,
    parameter int PC_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ALUCTRL_W-1:0]       out_alucontrol,
    output logic [PC_W-1:0]            out_pc,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_rd,
    output logic                       out_is_branch,
    output logic                       out_is_mem,
    output logic                       out_is_hilo,
    output logic                       out_ri,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ALUCTRL_W + PC_W + 18;

    localparam logic [7:0] EXE_NOP_OP    = 8'h00;
    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [7:0] EXE_XOR_OP    = 8'h26;
    localparam logic [7:0] EXE_NOR_OP    = 8'h27;
    localparam logic [7:0] EXE_ANDI_OP   = 8'h59;
    localparam logic [7:0] EXE_ORI_OP    = 8'h5A;
    localparam logic [7:0] EXE_XORI_OP   = 8'h5B;
    localparam logic [7:0] EXE_LUI_OP    = 8'h5C;
    localparam logic [7:0] EXE_SLL_OP    = 8'h7C;
    localparam logic [7:0] EXE_SLLV_OP   = 8'h04;
    localparam logic [7:0] EXE_SRL_OP    = 8'h02;
    localparam logic [7:0] EXE_SRLV_OP   = 8'h06;
    localparam logic [7:0] EXE_SRA_OP    = 8'h03;
    localparam logic [7:0] EXE_SRAV_OP   = 8'h07;
    localparam logic [7:0] EXE_MOVZ_OP   = 8'h0A;
    localparam logic [7:0] EXE_MOVN_OP   = 8'h0B;
    localparam logic [7:0] EXE_MFHI_OP   = 8'h10;
    localparam logic [7:0] EXE_MTHI_OP   = 8'h11;
    localparam logic [7:0] EXE_MFLO_OP   = 8'h12;
    localparam logic [7:0] EXE_MTLO_OP   = 8'h13;
    localparam logic [7:0] EXE_SLT_OP    = 8'h2A;
    localparam logic [7:0] EXE_SLTU_OP   = 8'h2B;
    localparam logic [7:0] EXE_SLTI_OP   = 8'h57;
    localparam logic [7:0] EXE_SLTIU_OP  = 8'h58;
    localparam logic [7:0] EXE_ADD_OP    = 8'h20;
    localparam logic [7:0] EXE_ADDU_OP   = 8'h21;
    localparam logic [7:0] EXE_SUB_OP    = 8'h22;
    localparam logic [7:0] EXE_SUBU_OP   = 8'h23;
    localparam logic [7:0] EXE_ADDI_OP   = 8'h55;
    localparam logic [7:0] EXE_ADDIU_OP  = 8'h56;
    localparam logic [7:0] EXE_MULT_OP   = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP  = 8'h19;
    localparam logic [7:0] EXE_DIV_OP    = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP   = 8'h1B;
    localparam logic [7:0] EXE_J_OP      = 8'h4F;
    localparam logic [7:0] EXE_JAL_OP    = 8'h50;
    localparam logic [7:0] EXE_JR_OP     = 8'h08;
    localparam logic [7:0] EXE_JALR_OP   = 8'h09;
    localparam logic [7:0] EXE_BEQ_OP    = 8'h51;
    localparam logic [7:0] EXE_BNE_OP    = 8'h52;
    localparam logic [7:0] EXE_BLEZ_OP   = 8'h53;
    localparam logic [7:0] EXE_BGTZ_OP   = 8'h54;
    localparam logic [7:0] EXE_BLTZ_OP   = 8'h40;
    localparam logic [7:0] EXE_BGEZ_OP   = 8'h41;
    localparam logic [7:0] EXE_BLTZAL_OP = 8'h4A;
    localparam logic [7:0] EXE_BGEZAL_OP = 8'h4B;
    localparam logic [7:0] EXE_LB_OP     = 8'hE0;
    localparam logic [7:0] EXE_LH_OP     = 8'hE1;
    localparam logic [7:0] EXE_LW_OP     = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP    = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP    = 8'hE5;
    localparam logic [7:0] EXE_SB_OP     = 8'hE8;
    localparam logic [7:0] EXE_SH_OP     = 8'hE9;
    localparam logic [7:0] EXE_SW_OP     = 8'hEB;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt_f;
    logic [7:0] dec_code;
    logic       dec_br;
    logic       dec_mem;
    logic       dec_hilo;
    logic       dec_hit;

    assign op    = in_instr[31:26];
    assign funct = in_instr[5:0];
    assign rt_f  = in_instr[20:16];

    always_comb begin
        dec_code = EXE_NOP_OP;
        dec_br   = 1'b0;
        dec_mem  = 1'b0;
        dec_hilo = 1'b0;
        dec_hit  = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00: dec_code = EXE_SLL_OP;
                    6'h02: dec_code = EXE_SRL_OP;
                    6'h03: dec_code = EXE_SRA_OP;
                    6'h04: dec_code = EXE_SLLV_OP;
                    6'h06: dec_code = EXE_SRLV_OP;
                    6'h07: dec_code = EXE_SRAV_OP;
                    6'h08: begin dec_code = EXE_JR_OP;    dec_br   = 1'b1; end
                    6'h09: begin dec_code = EXE_JALR_OP;  dec_br   = 1'b1; end
                    6'h0A: dec_code = EXE_MOVZ_OP;
                    6'h0B: dec_code = EXE_MOVN_OP;
                    6'h10: begin dec_code = EXE_MFHI_OP;  dec_hilo = 1'b1; end
                    6'h11: begin dec_code = EXE_MTHI_OP;  dec_hilo = 1'b1; end
                    6'h12: begin dec_code = EXE_MFLO_OP;  dec_hilo = 1'b1; end
                    6'h13: begin dec_code = EXE_MTLO_OP;  dec_hilo = 1'b1; end
                    6'h18: begin dec_code = EXE_MULT_OP;  dec_hilo = 1'b1; end
                    6'h19: begin dec_code = EXE_MULTU_OP; dec_hilo = 1'b1; end
                    6'h1A: begin dec_code = EXE_DIV_OP;   dec_hilo = 1'b1; end
                    6'h1B: begin dec_code = EXE_DIVU_OP;  dec_hilo = 1'b1; end
                    6'h20: dec_code = EXE_ADD_OP;
                    6'h21: dec_code = EXE_ADDU_OP;
                    6'h22: dec_code = EXE_SUB_OP;
                    6'h23: dec_code = EXE_SUBU_OP;
                    6'h24: dec_code = EXE_AND_OP;
                    6'h25: dec_code = EXE_OR_OP;
                    6'h26: dec_code = EXE_XOR_OP;
                    6'h27: dec_code = EXE_NOR_OP;
                    6'h2A: dec_code = EXE_SLT_OP;
                    6'h2B: dec_code = EXE_SLTU_OP;
                    default: dec_hit = 1'b0;
                endcase
            end
            // REGIMM: branch kind lives in the rt field
            6'h01: begin
                dec_br = 1'b1;
                case (rt_f)
                    5'h00: dec_code = EXE_BLTZ_OP;
                    5'h01: dec_code = EXE_BGEZ_OP;
                    5'h10: dec_code = EXE_BLTZAL_OP;
                    5'h11: dec_code = EXE_BGEZAL_OP;
                    default: begin dec_hit = 1'b0; dec_br = 1'b0; end
                endcase
            end
            6'h02: begin dec_code = EXE_J_OP;    dec_br  = 1'b1; end
            6'h03: begin dec_code = EXE_JAL_OP;  dec_br  = 1'b1; end
            6'h04: begin dec_code = EXE_BEQ_OP;  dec_br  = 1'b1; end
            6'h05: begin dec_code = EXE_BNE_OP;  dec_br  = 1'b1; end
            6'h06: begin dec_code = EXE_BLEZ_OP; dec_br  = 1'b1; end
            6'h07: begin dec_code = EXE_BGTZ_OP; dec_br  = 1'b1; end
            6'h08: dec_code = EXE_ADDI_OP;
            6'h09: dec_code = EXE_ADDIU_OP;
            6'h0A: dec_code = EXE_SLTI_OP;
            6'h0B: dec_code = EXE_SLTIU_OP;
            6'h0C: dec_code = EXE_ANDI_OP;
            6'h0D: dec_code = EXE_ORI_OP;
            6'h0E: dec_code = EXE_XORI_OP;
            6'h0F: dec_code = EXE_LUI_OP;
            6'h20: begin dec_code = EXE_LB_OP;   dec_mem = 1'b1; end
            6'h21: begin dec_code = EXE_LH_OP;   dec_mem = 1'b1; end
            6'h23: begin dec_code = EXE_LW_OP;   dec_mem = 1'b1; end
            6'h24: begin dec_code = EXE_LBU_OP;  dec_mem = 1'b1; end
            6'h25: begin dec_code = EXE_LHU_OP;  dec_mem = 1'b1; end
            6'h28: begin dec_code = EXE_SB_OP;   dec_mem = 1'b1; end
            6'h29: begin dec_code = EXE_SH_OP;   dec_mem = 1'b1; end
            6'h2B: begin dec_code = EXE_SW_OP;   dec_mem = 1'b1; end
            default: dec_hit = 1'b0;
        endcase
    end

    logic [ENT_W-1:0] ent_new;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign ent_new = {ALUCTRL_W'(dec_code), in_pc, in_instr[25:21], in_instr[20:16],
                      in_instr[15:11], dec_br, dec_mem, dec_hilo};

    // Gating with rst keeps in_ready low during reset without waiting a cycle for state.
    assign in_ready  = !rst && (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign do_push   = in_valid && in_ready && !flush;
    assign do_pop    = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = ent_new;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head           = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_alucontrol = head[ENT_W-1 -: ALUCTRL_W];
    assign out_pc         = head[PC_W+17 -: PC_W];
    assign out_rs         = head[17:13];
    assign out_rt         = head[12:8];
    assign out_rd         = head[7:3];
    assign out_is_branch  = head[2];
    assign out_is_mem     = head[1];
    assign out_is_hilo    = head[0];

`ifdef ALUDEC_RI_EN
    logic ri_q [DEPTH];
    logic ri_d [DEPTH];

    always_comb begin
        ri_d = ri_q;
        if (do_push) begin
            ri_d[wr_ptr_q] = !dec_hit;
        end
    end

    always_ff @(posedge clk) begin
        ri_q <= ri_d;
    end

    assign out_ri = out_valid ? ri_q[rd_ptr_q] : 1'b0;
`else
    logic unused_hit;
    assign unused_hit = dec_hit;
    assign out_ri     = 1'b0;
`endif

    logic [4:0] unused_shamt;
    assign unused_shamt = in_instr[10:6];

endmodule

// File: tb/tb_aludec_pipe.sv
// Self-checking bench for aludec_pipe: directed scenarios plus random traffic against
// a table-driven decode model and a queue-based FIFO model.
module tb_aludec_pipe;

    localparam int DEPTH = 2;

`ifdef ALUDEC_RI_EN
    localparam bit RI_ON = 1'b1;
`else
    localparam bit RI_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_alucontrol;
    logic [31:0] out_pc;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic        out_is_branch, out_is_mem, out_is_hilo, out_ri;
    logic [1:0]  count;

    aludec_pipe #(.DEPTH(DEPTH), .ALUCTRL_W(8), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_alucontrol(out_alucontrol),
        .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_is_branch(out_is_branch), .out_is_mem(out_is_mem), .out_is_hilo(out_is_hilo),
        .out_ri(out_ri), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Encoding table: (op, selector, code, class) with class 0=plain 1=branch 2=mem 3=hilo.
    // The selector is funct for op 0, rt for op 1, and ignored otherwise.
    logic [5:0] t_op[$];
    logic [5:0] t_sel[$];
    logic [7:0] t_code[$];
    int         t_cls[$];

    // Expected entries: {code, pc, rs, rt, rd, br, mem, hilo, ri}
    logic [58:0] exp_q[$];
    logic [7:0]  dut_codes[$];
    bit          last_push;

    task automatic add(input logic [5:0] o, input logic [5:0] s, input logic [7:0] c, input int k);
        t_op.push_back(o); t_sel.push_back(s); t_code.push_back(c); t_cls.push_back(k);
    endtask

    task automatic init_table();
        add(6'h00,6'h00,8'h7C,0); add(6'h00,6'h02,8'h02,0); add(6'h00,6'h03,8'h03,0);
        add(6'h00,6'h04,8'h04,0); add(6'h00,6'h06,8'h06,0); add(6'h00,6'h07,8'h07,0);
        add(6'h00,6'h08,8'h08,1); add(6'h00,6'h09,8'h09,1); add(6'h00,6'h0A,8'h0A,0);
        add(6'h00,6'h0B,8'h0B,0); add(6'h00,6'h10,8'h10,3); add(6'h00,6'h11,8'h11,3);
        add(6'h00,6'h12,8'h12,3); add(6'h00,6'h13,8'h13,3); add(6'h00,6'h18,8'h18,3);
        add(6'h00,6'h19,8'h19,3); add(6'h00,6'h1A,8'h1A,3); add(6'h00,6'h1B,8'h1B,3);
        add(6'h00,6'h20,8'h20,0); add(6'h00,6'h21,8'h21,0); add(6'h00,6'h22,8'h22,0);
        add(6'h00,6'h23,8'h23,0); add(6'h00,6'h24,8'h24,0); add(6'h00,6'h25,8'h25,0);
        add(6'h00,6'h26,8'h26,0); add(6'h00,6'h27,8'h27,0); add(6'h00,6'h2A,8'h2A,0);
        add(6'h00,6'h2B,8'h2B,0);
        add(6'h01,6'h00,8'h40,1); add(6'h01,6'h01,8'h41,1);
        add(6'h01,6'h10,8'h4A,1); add(6'h01,6'h11,8'h4B,1);
        add(6'h02,6'h00,8'h4F,1); add(6'h03,6'h00,8'h50,1); add(6'h04,6'h00,8'h51,1);
        add(6'h05,6'h00,8'h52,1); add(6'h06,6'h00,8'h53,1); add(6'h07,6'h00,8'h54,1);
        add(6'h08,6'h00,8'h55,0); add(6'h09,6'h00,8'h56,0); add(6'h0A,6'h00,8'h57,0);
        add(6'h0B,6'h00,8'h58,0); add(6'h0C,6'h00,8'h59,0); add(6'h0D,6'h00,8'h5A,0);
        add(6'h0E,6'h00,8'h5B,0); add(6'h0F,6'h00,8'h5C,0);
        add(6'h20,6'h00,8'hE0,2); add(6'h21,6'h00,8'hE1,2); add(6'h23,6'h00,8'hE3,2);
        add(6'h24,6'h00,8'hE4,2); add(6'h25,6'h00,8'hE5,2); add(6'h28,6'h00,8'hE8,2);
        add(6'h29,6'h00,8'hE9,2); add(6'h2B,6'h00,8'hEB,2);
    endtask

    function automatic logic [58:0] ref_entry(input logic [31:0] instr, input logic [31:0] pc);
        logic [7:0] code = 8'h00;
        int         cls  = 0;
        bit         hit  = 0;
        logic [5:0] op   = instr[31:26];
        logic [5:0] sel  = (op == 6'h00) ? instr[5:0] : {1'b0, instr[20:16]};
        for (int i = 0; i < t_op.size(); i++) begin
            if (!hit && t_op[i] == op && (op > 6'h01 || t_sel[i] == sel)) begin
                hit = 1; code = t_code[i]; cls = t_cls[i];
            end
        end
        return {code, pc, instr[25:21], instr[20:16], instr[15:11],
                cls == 1, cls == 2, cls == 3, RI_ON && !hit};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, t_op.size());
        if (k < t_op.size()) begin
            w[31:26] = t_op[k];
            if (t_op[k] == 6'h00) w[5:0] = t_sel[k];
            if (t_op[k] == 6'h01) w[20:16] = t_sel[k][4:0];
        end
        return w;
    endfunction

    function automatic logic [59:0] pack_obs();
        return {out_valid, out_alucontrol, out_pc, out_rs, out_rt, out_rd,
                out_is_branch, out_is_mem, out_is_hilo, out_ri};
    endfunction

    function automatic logic [59:0] exp_head();
        return (exp_q.size() != 0) ? {1'b1, exp_q[0]} : 60'd0;
    endfunction

    // Advance one clock, updating the model with what the rising edge commits.
    task automatic tick();
        bit rdy, push, pop;
        rdy  = !rst && (exp_q.size() < DEPTH);
        push = in_valid && rdy && !flush;
        pop  = (exp_q.size() != 0) && out_ready && !flush && !rst;
        last_push = push;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(ref_entry(in_instr, in_pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
        @(negedge clk);
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (pack_obs() !== 60'd0) $display("FAIL reset_outputs: got %h expected 0", pack_obs()); else n_pass++;
        rst = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        in_valid = 1; in_instr = 32'h00221820; in_pc = 32'h100; out_ready = 1;
        tick();
        in_valid = 0;
        n_checks++;
        if (pack_obs() !== {1'b1, 8'h20, 32'h100, 5'd1, 5'd2, 5'd3, 4'b0000})
            $display("FAIL add_head: got %h expected %h", pack_obs(),
                     {1'b1, 8'h20, 32'h100, 5'd1, 5'd2, 5'd3, 4'b0000});
        else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || count !== 2'd0) $display("FAIL add_drain: valid %b count %0d expected 0/0", out_valid, count); else n_pass++;
    endtask

    task automatic test_full_hold();
        logic [23:0] got;
        out_ready = 0; in_valid = 1;
        in_instr = 32'h3421FFFF; in_pc = 32'h104; tick();
        in_instr = 32'h8C220004; in_pc = 32'h108; tick();
        in_instr = 32'h0041001A; in_pc = 32'h10C;
        #1;
        n_checks++; if (count !== 2'd2 || in_ready !== 1'b0) $display("FAIL full_state: count %0d in_ready %b expected 2/0", count, in_ready); else n_pass++;
        tick();
        n_checks++; if (count !== 2'd2) $display("FAIL full_hold_count: got %0d expected 2", count); else n_pass++;
        n_checks++; if (out_alucontrol !== 8'h5A) $display("FAIL full_hold_head: got %h expected 5a", out_alucontrol); else n_pass++;
        out_ready = 1; dut_codes.delete();
        for (int cyc = 0; cyc < 12 && (in_valid || exp_q.size() != 0); cyc++) begin
            n_checks++; if (pack_obs() !== exp_head()) $display("FAIL drain_head: got %h expected %h", pack_obs(), exp_head()); else n_pass++;
            if (out_valid === 1'b1) dut_codes.push_back(out_alucontrol);
            tick();
            if (last_push) in_valid = 0;
        end
        n_checks++; if (in_valid || exp_q.size() != 0) $display("FAIL drain_timeout: left %0d expected 0", exp_q.size()); else n_pass++;
        got = '0;
        foreach (dut_codes[i]) got = {got[15:0], dut_codes[i]};
        n_checks++; if (dut_codes.size() != 3 || got !== 24'h5AE31A) $display("FAIL order: got %0d codes %h expected 3 codes 5ae31a", dut_codes.size(), got); else n_pass++;
    endtask

    task automatic test_regimm();
        logic [31:0] prog [2];
        logic [15:0] got;
        int idx;
        prog[0] = 32'h04310008; prog[1] = 32'h04100004;
        out_ready = 1; idx = 0; dut_codes.delete();
        in_valid = 1; in_instr = prog[0]; in_pc = 32'h200;
        for (int cyc = 0; cyc < 12 && (idx < 2 || exp_q.size() != 0); cyc++) begin
            n_checks++; if (pack_obs() !== exp_head()) $display("FAIL regimm_head: got %h expected %h", pack_obs(), exp_head()); else n_pass++;
            if (out_valid === 1'b1 && out_is_branch === 1'b1) dut_codes.push_back(out_alucontrol);
            tick();
            if (last_push) begin
                idx++;
                if (idx < 2) begin in_instr = prog[idx]; in_pc = 32'h200 + 32'(idx * 4); end
                else in_valid = 0;
            end
        end
        in_valid = 0;
        got = '0;
        foreach (dut_codes[i]) got = {got[7:0], dut_codes[i]};
        n_checks++; if (dut_codes.size() != 2 || got !== 16'h4B4A) $display("FAIL regimm_order: got %0d branch codes %h expected 2 codes 4b4a", dut_codes.size(), got); else n_pass++;
    endtask

    task automatic test_wrap();
        int pushes;
        out_ready = 0; in_valid = 1;
        in_instr = rand_instr(); in_pc = $urandom; tick();
        in_instr = rand_instr(); in_pc = $urandom; tick();
        out_ready = 1; pushes = 0;
        in_instr = rand_instr(); in_pc = $urandom;
        for (int cyc = 0; cyc < 80 && pushes < 16; cyc++) begin
            n_checks++; if (count !== 2'(exp_q.size())) $display("FAIL wrap_count: got %0d expected %0d", count, exp_q.size()); else n_pass++;
            n_checks++; if (pack_obs() !== exp_head()) $display("FAIL wrap_head: got %h expected %h", pack_obs(), exp_head()); else n_pass++;
            tick();
            if (last_push) begin pushes++; in_instr = rand_instr(); in_pc = $urandom; end
        end
        in_valid = 0;
        n_checks++; if (pushes != 16) $display("FAIL wrap_pushes: got %0d expected 16", pushes); else n_pass++;
        for (int cyc = 0; cyc < 8 && exp_q.size() != 0; cyc++) begin
            n_checks++; if (pack_obs() !== exp_head()) $display("FAIL wrap_drain: got %h expected %h", pack_obs(), exp_head()); else n_pass++;
            tick();
        end
        n_checks++; if (count !== 2'd0) $display("FAIL wrap_empty: got %0d expected 0", count); else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1;
        in_instr = 32'h00221820; in_pc = 32'h300; tick();
        in_instr = 32'h3421FFFF; in_pc = 32'h304; tick();
        n_checks++; if (count !== 2'd2) $display("FAIL flush_pre: got %0d expected 2", count); else n_pass++;
        out_ready = 1; flush = 1; in_instr = 32'h8C220004; in_pc = 32'h308;
        tick();
        flush = 0; in_valid = 0;
        n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_clear: count %0d valid %b expected 0/0", count, out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_dropped: valid %b expected 0", out_valid); else n_pass++;
        out_ready = 0; in_valid = 1;
        in_instr = 32'h0041001A; in_pc = 32'h310; tick();
        in_instr = 32'h04310008; in_pc = 32'h314; tick();
        rst = 1; out_ready = 1; in_instr = 32'h00221820; in_pc = 32'h318;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else n_pass++;
        tick();
        rst = 0; in_valid = 0;
        n_checks++; if (count !== 2'd0 || out_valid !== 1'b0) $display("FAIL rst_clear: count %0d valid %b expected 0/0", count, out_valid); else n_pass++;
        tick();
        n_checks++; if (pack_obs() !== 60'd0) $display("FAIL rst_dropped: got %h expected 0", pack_obs()); else n_pass++;
    endtask

    task automatic test_ri();
        out_ready = 1; in_valid = 1; in_instr = 32'hFC000000; in_pc = 32'h400;
        tick();
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1 || out_alucontrol !== 8'h00) $display("FAIL ri_code: valid %b code %h expected 1/00", out_valid, out_alucontrol); else n_pass++;
        n_checks++; if (out_ri !== RI_ON) $display("FAIL ri_flag: got %b expected %b", out_ri, RI_ON); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_instr  = rand_instr();
            in_pc     = $urandom;
            #1;
            n_checks++; if (in_ready !== (exp_q.size() < DEPTH)) $display("FAIL rnd_in_ready: got %b expected %b", in_ready, exp_q.size() < DEPTH); else n_pass++;
            n_checks++; if (count !== 2'(exp_q.size())) $display("FAIL rnd_count: got %0d expected %0d", count, exp_q.size()); else n_pass++;
            n_checks++; if (pack_obs() !== exp_head()) $display("FAIL rnd_head: got %h expected %h", pack_obs(), exp_head()); else n_pass++;
            tick();
        end
        flush = 0; in_valid = 0;
    endtask

    initial begin
        init_table();
        test_reset();
        test_basic();
        test_full_hold();
        test_regimm();
        test_wrap();
        test_flush();
        test_ri();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
